// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Purpose : shared constants and types for the MiniCPU fetch-stage PC generator.
//           Holds the PC step, the default hold level, the default reset and trap
//           vectors, the jump/reset enable encodings and the FSM state type.
// Ports   : none (package).
// Config  : PC_MISALIGN_EXC_EN (used by pc_gen / pc_gen_next_sel, not here).
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    // Distance between consecutive instruction fetches, in bytes.
    localparam int PC_STEP = 4;

    // Default hold level at which the PC freezes.
    localparam int HOLD_PC = 1;

    // Default boot and misaligned-jump trap vectors.
    localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] CPU_TRAP_ADDR  = 32'h0000_0004;

    // Active levels of the jump request and of the resets.
    localparam logic JUMP_ENABLE = 1'b1;
    localparam logic RST_ENABLE  = 1'b1;

    // BOOT: first cycle after reset, no fetch request yet.
    // RUN : fetch request always valid; only a reset leaves this state.
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen_next_sel.sv
// -----------------------------------------------------------------------------
// pc_gen_next_sel
// Purpose : combinational next-state selection for pc_gen. It chooses the next
//           PC, valid and state, and the redirect / misalign pulses, and it
//           reports whether the current fetch request is acknowledged this edge.
//           Priority is jump > hold > advance. Reset is applied by the registers
//           in pc_gen.
// Ports   : state_i        current FSM state
//           jump_flag_i    redirect request
//           jump_addr_i    redirect target
//           hold_flag_i    pipeline hold level
//           fetch_valid_i  current registered fetch_valid
//           fetch_ready_i  imem accepts pc_i this cycle
//           pc_i           current registered PC
//           state_d_o      next FSM state
//           pc_d_o         next PC
//           valid_d_o      next fetch_valid
//           redirect_d_o   next redirect pulse
//           misalign_d_o   next misalign pulse (only with PC_MISALIGN_EXC_EN)
//           fetch_ack_o    an accepted fetch that the counter should record
// Config  : PC_MISALIGN_EXC_EN - a jump to an address with bits [1:0] != 0 goes
//           to TRAP_ADDR and raises misalign. Without it, those bits are cleared.
// -----------------------------------------------------------------------------
module pc_gen_next_sel
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = HOLD_PC,
    parameter logic [ADDR_W-1:0] TRAP_ADDR   = ADDR_W'(CPU_TRAP_ADDR)
) (
    input  pc_state_e           state_i,
    input  logic                jump_flag_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic [HOLD_W-1:0]   hold_flag_i,
    input  logic                fetch_valid_i,
    input  logic                fetch_ready_i,
    input  logic [ADDR_W-1:0]   pc_i,
    output pc_state_e           state_d_o,
    output logic [ADDR_W-1:0]   pc_d_o,
    output logic                valid_d_o,
    output logic                redirect_d_o,
`ifdef PC_MISALIGN_EXC_EN
    output logic                misalign_d_o,
`endif
    output logic                fetch_ack_o
);

    logic jump;
    logic hold_pc;
    logic handshake;
    logic running;

    assign jump      = (jump_flag_i == JUMP_ENABLE);
    assign hold_pc   = (hold_flag_i >= HOLD_W'(HOLD_PC_LVL));
    assign running   = (state_i == ST_RUN);
    assign handshake = fetch_valid_i & fetch_ready_i;

    // A jump aborts the outstanding request, so that request is not counted.
    // An ack during hold is still counted even though the PC does not move.
    assign fetch_ack_o = handshake & ~jump;

`ifndef PC_MISALIGN_EXC_EN
    // The low jump-address bits and the trap vector are only used by the
    // misalign trap. This signal marks them as intentionally unused.
    logic unused_misalign_inputs;
    assign unused_misalign_inputs = ^{jump_addr_i[1:0], TRAP_ADDR};
`endif

    always_comb begin
        state_d_o    = ST_RUN;   // BOOT lasts one cycle. RUN is left only by reset.
        pc_d_o       = pc_i;
        valid_d_o    = 1'b1;
        redirect_d_o = 1'b0;
`ifdef PC_MISALIGN_EXC_EN
        misalign_d_o = 1'b0;
`endif
        if (jump) begin
            redirect_d_o = 1'b1;
            pc_d_o       = {jump_addr_i[ADDR_W-1:2], 2'b00};
`ifdef PC_MISALIGN_EXC_EN
            if (jump_addr_i[1:0] != 2'b00) begin
                pc_d_o       = TRAP_ADDR;
                misalign_d_o = 1'b1;
            end
`endif
        end else if (hold_pc) begin
            pc_d_o = pc_i;
        end else if (running && handshake) begin
            // Advance only on an acknowledged request. Valid without ready holds the address.
            pc_d_o = pc_i + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Purpose : program-counter generator for the MiniCPU fetch stage. It holds the
//           PC, fetch-valid, redirect, misalign and fetch-counter registers and
//           the BOOT/RUN state. The next-state choice is made in pc_gen_next_sel.
// Ports   : clk            clock, posedge
//           rst            synchronous active-high reset
//           jtag_rst_i     debug core reset, synchronous, same effect as rst
//           jump_flag_i    redirect request from ex/ctrl
//           jump_addr_i    redirect target
//           hold_flag_i    pipeline hold level from ctrl
//           fetch_ready_i  imem accepts pc_o this cycle
//           pc_o           current fetch address
//           fetch_valid_o  pc_o is a valid fetch request
//           redirect_o     pulse: pc_o was loaded by a jump on the last edge
//           fetch_cnt_o    accepted fetches since reset, wraps
//           misalign_o     pulse on a misaligned jump (only with PC_MISALIGN_EXC_EN)
// Config  : PC_MISALIGN_EXC_EN - enables the misaligned-jump trap and misalign_o.
// Handshake: fetch_valid_o/fetch_ready_i follow valid/ready rules. A request is
//           accepted on an edge where both are high. While valid is high and
//           ready is low, pc_o stays stable. A jump or a reset may replace or
//           drop a pending request, and no acknowledge is owed for it.
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(CPU_RESET_ADDR),
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = HOLD_PC,
    parameter int                CNT_W       = 32,
    parameter logic [ADDR_W-1:0] TRAP_ADDR   = ADDR_W'(CPU_TRAP_ADDR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jtag_rst_i,
    input  logic                jump_flag_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic [HOLD_W-1:0]   hold_flag_i,
    input  logic                fetch_ready_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                fetch_valid_o,
    output logic                redirect_o,
`ifdef PC_MISALIGN_EXC_EN
    output logic                misalign_o,
`endif
    output logic [CNT_W-1:0]    fetch_cnt_o
);

    pc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               redirect_q, redirect_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               fetch_ack;
    logic               core_rst;
`ifdef PC_MISALIGN_EXC_EN
    logic               misalign_q, misalign_d;
`endif

    assign core_rst = (rst == RST_ENABLE) || (jtag_rst_i == RST_ENABLE);

    pc_gen_next_sel #(
        .ADDR_W      (ADDR_W),
        .HOLD_W      (HOLD_W),
        .HOLD_PC_LVL (HOLD_PC_LVL),
        .TRAP_ADDR   (TRAP_ADDR)
    ) u_next_sel (
        .state_i       (state_q),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .fetch_valid_i (valid_q),
        .fetch_ready_i (fetch_ready_i),
        .pc_i          (pc_q),
        .state_d_o     (state_d),
        .pc_d_o        (pc_d),
        .valid_d_o     (valid_d),
        .redirect_d_o  (redirect_d),
`ifdef PC_MISALIGN_EXC_EN
        .misalign_d_o  (misalign_d),
`endif
        .fetch_ack_o   (fetch_ack)
    );

    always_ff @(posedge clk) begin
        if (core_rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            cnt_q      <= '0;
`ifdef PC_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            if (fetch_ack) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
`ifdef PC_MISALIGN_EXC_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = valid_q;
    assign redirect_o    = redirect_q;
    assign fetch_cnt_o   = cnt_q;
`ifdef PC_MISALIGN_EXC_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Purpose : self-checking bench for pc_gen. It drives a 32-bit instance and an
//           8-bit instance (ADDR_W=8, CNT_W=8) from shared stimulus and compares
//           both against a behavioural model after every edge. Directed scenes
//           are followed by randomized traffic.
// Config  : PC_MISALIGN_EXC_EN - also checks the trap path and misalign_o.
// -----------------------------------------------------------------------------
module tb_pc_gen;

`ifdef PC_MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam int HOLD_LVL = 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic        jtag_rst;
    logic        jump;
    logic [31:0] jaddr;
    logic [2:0]  hold;
    logic        ready;

    // ---------------- DUT outputs ----------------
    logic [31:0] pc32;
    logic        valid32, redir32;
    logic [31:0] cnt32;
    logic [7:0]  pc8;
    logic        valid8, redir8;
    logic [7:0]  cnt8;
    logic        mis32, mis8;

    pc_gen #(.ADDR_W(32), .CNT_W(32)) dut32 (
        .clk           (clk),
        .rst           (rst),
        .jtag_rst_i    (jtag_rst),
        .jump_flag_i   (jump),
        .jump_addr_i   (jaddr),
        .hold_flag_i   (hold),
        .fetch_ready_i (ready),
        .pc_o          (pc32),
        .fetch_valid_o (valid32),
        .redirect_o    (redir32),
`ifdef PC_MISALIGN_EXC_EN
        .misalign_o    (mis32),
`endif
        .fetch_cnt_o   (cnt32)
    );

    pc_gen #(.ADDR_W(8), .CNT_W(8)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .jtag_rst_i    (jtag_rst),
        .jump_flag_i   (jump),
        .jump_addr_i   (jaddr[7:0]),
        .hold_flag_i   (hold),
        .fetch_ready_i (ready),
        .pc_o          (pc8),
        .fetch_valid_o (valid8),
        .redirect_o    (redir8),
`ifdef PC_MISALIGN_EXC_EN
        .misalign_o    (mis8),
`endif
        .fetch_cnt_o   (cnt8)
    );

`ifndef PC_MISALIGN_EXC_EN
    assign mis32 = 1'b0;
    assign mis8  = 1'b0;
`endif

    // ---------------- scoreboard / model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc[2];
    logic [31:0] m_cnt[2];
    logic        m_valid[2];
    logic        m_redir[2];
    logic        m_mis[2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Applies one clock edge to instance i (0: 32-bit, 1: 8-bit) using the spec rules.
    task automatic model_step(input int i);
        logic [31:0] msk;
        msk = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        if (rst || jtag_rst) begin
            m_pc[i]    = 32'h0;
            m_cnt[i]   = 32'h0;
            m_valid[i] = 1'b0;
            m_redir[i] = 1'b0;
            m_mis[i]   = 1'b0;
        end else begin
            if (m_valid[i] && ready && !jump)
                m_cnt[i] = (m_cnt[i] + 1) & msk;
            if (jump) begin
                m_redir[i] = 1'b1;
                if (MIS_EN && (jaddr[1:0] != 2'b00)) begin
                    m_pc[i]  = 32'h4;
                    m_mis[i] = 1'b1;
                end else begin
                    m_pc[i]  = jaddr & msk & 32'hFFFF_FFFC;
                    m_mis[i] = 1'b0;
                end
            end else begin
                m_redir[i] = 1'b0;
                m_mis[i]   = 1'b0;
                if (m_valid[i] && ready && (hold < HOLD_LVL))
                    m_pc[i] = (m_pc[i] + 4) & msk;
            end
            m_valid[i] = 1'b1;
        end
    endtask

    // One clock edge: update the model at the edge and compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_eq("pc32",    64'(pc32),    64'(m_pc[0]));
        check_eq("valid32", 64'(valid32), 64'(m_valid[0]));
        check_eq("redir32", 64'(redir32), 64'(m_redir[0]));
        check_eq("cnt32",   64'(cnt32),   64'(m_cnt[0]));
        check_eq("pc8",     64'(pc8),     64'(m_pc[1]));
        check_eq("valid8",  64'(valid8),  64'(m_valid[1]));
        check_eq("redir8",  64'(redir8),  64'(m_redir[1]));
        check_eq("cnt8",    64'(cnt8),    64'(m_cnt[1]));
        if (MIS_EN) begin
            check_eq("mis32", 64'(mis32), 64'(m_mis[0]));
            check_eq("mis8",  64'(mis8),  64'(m_mis[1]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic j, input logic [31:0] a, input logic [2:0] h, input logic r);
        jump  = j;
        jaddr = a;
        hold  = h;
        ready = r;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_redir[i] = 0; m_mis[i] = 0;
        end
        rst = 1'b1;
        jtag_rst = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        #2;
        tick();
        tick();
        check_eq("reset_pc",    64'(pc32),    64'h0);
        check_eq("reset_valid", 64'(valid32), 64'h0);

        // Boot with ready=1: the PC sequence is 0,0,4,8,C and cnt is 3 after three acks.
        rst = 1'b0;
        tick();
        check_eq("boot_pc",    64'(pc32),    64'h0);
        check_eq("boot_valid", 64'(valid32), 64'h1);
        tick();
        tick();
        check_eq("boot_pc8", 64'(pc32), 64'h8);
        // ready low for three cycles at pc 8
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        repeat (3) tick();
        check_eq("stall_pc",  64'(pc32),  64'h8);
        check_eq("stall_cnt", 64'(cnt32), 64'h2);
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        tick();
        check_eq("resume_pc",  64'(pc32),  64'hC);
        check_eq("resume_cnt", 64'(cnt32), 64'h3);

        // A jump overrides hold, and the jump edge does not count.
        drive(1'b1, 32'h100, 3'd1, 1'b1);
        tick();
        check_eq("jump_pc",    64'(pc32),    64'h100);
        check_eq("jump_redir", 64'(redir32), 64'h1);
        check_eq("jump_cnt",   64'(cnt32),   64'h3);
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        tick();
        check_eq("post_jump_redir", 64'(redir32), 64'h0);
        check_eq("post_jump_pc",    64'(pc32),    64'h104);

        // hold=2 at pc 0x10: the PC freezes and the acks still count.
        drive(1'b1, 32'h10, 3'd0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'd2, 1'b1);
        repeat (2) tick();
        check_eq("hold_pc",  64'(pc32),  64'h10);
        check_eq("hold_cnt", 64'(cnt32), 64'h6);

        // Wrap of the 8-bit PC from 0xFC to 0x00.
        drive(1'b1, 32'hFC, 3'd0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        tick();
        check_eq("wrap_pc8",  64'(pc8),  64'h0);
        check_eq("wrap_pc32", 64'(pc32), 64'h100);

        // Misaligned jump target.
        drive(1'b1, 32'h102, 3'd0, 1'b1);
        tick();
        check_eq("misalign_pc", 64'(pc32), MIS_EN ? 64'h4 : 64'h100);
        check_eq("misalign_o",  64'(mis32), MIS_EN ? 64'h1 : 64'h0);
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        tick();

        // Debug reset in the middle of the run.
        tick();
        jtag_rst = 1'b1;
        tick();
        check_eq("jtag_pc",    64'(pc32),    64'h0);
        check_eq("jtag_valid", 64'(valid32), 64'h0);
        check_eq("jtag_cnt",   64'(cnt32),   64'h0);
        jtag_rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            jtag_rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 7) == 0), $urandom, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
